// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared types and encodings for the instruction sequencer:
//               sequencer states, opcode/op encodings, legality helper.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

  // Sequencer states; WAIT must be the reset/idle encoding.
  typedef enum logic [2:0] {
    WAIT      = 3'd0,
    DECODE    = 3'd1,
    WRITE_IMM = 3'd2,
    GET_A     = 3'd3,
    GET_B     = 3'd4,
    ALU       = 3'd5,
    ALU_MOV   = 3'd6,
    WRITE_REG = 3'd7
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op field for OPC_ALU doubles as the ALUop encoding.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  // op field variants for OPC_MOV.
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  // Every ALU op is defined; MOV only has the register and immediate forms.
  function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] op);
    return (opc == OPC_ALU) ||
           ((opc == OPC_MOV) && ((op == OP_MOV_REG) || (op == OP_MOV_IMM)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_controller_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Combinational field extraction from the instruction register
//               and sign extension of the 8-bit immediate to DW bits.
// Revision    : 1.0  initial release
// ============================================================================
module instr_decoder #(
  parameter int DW = 16
) (
  input  logic [15:0]   ir_i,
  output logic [2:0]    opcode_o,
  output logic [1:0]    op_o,
  output logic [2:0]    rn_o,
  output logic [2:0]    rd_o,
  output logic [1:0]    sh_o,
  output logic [2:0]    rm_o,
  output logic [DW-1:0] imm_o
);

  assign opcode_o = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign imm_o    = {{(DW-8){ir_i[7]}}, ir_i[7:0]};

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller
// Description : Moore instruction sequencer for the register/ALU datapath.
//               Captures one instruction in WAIT, decodes it and steps the
//               datapath strobes; one instruction in flight at a time.
// Revision    : 1.0  initial release
// ============================================================================
module cpu_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   instr,
  input  logic          load,
  input  logic          s,
  input  logic          Z_in,
  output logic          w,
  output logic          illegal,
  output logic [DW-1:0] imm_out,
  output logic          vsel,
  output logic          write,
  output logic [RW-1:0] writenum,
  output logic [RW-1:0] readnum,
  output logic          loada,
  output logic          loadb,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic          loadc,
  output logic          loads
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, sh;

  // Status flag is observation-only for this sequencer.
  logic unused_z;
  assign unused_z = Z_in;

  instr_decoder #(.DW(DW)) u_dec (
    .ir_i     (ir_q),
    .opcode_o (opcode),
    .op_o     (op),
    .rn_o     (rn),
    .rd_o     (rd),
    .sh_o     (sh),
    .rm_o     (rm),
    .imm_o    (imm_out)
  );

  // State, instruction register and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // IR only listens in WAIT; undefined encodings are flagged when decoded.
  always_comb begin
    ir_d      = ir_q;
    illegal_d = illegal_q;
    if ((state_q == WAIT) && load)
      ir_d = instr;
    if ((state_q == DECODE) && !is_legal(opcode, op))
      illegal_d = 1'b1;
  end

  // Next-state sequencing and Moore outputs from state and IR.
  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    vsel     = 1'b0;
    write    = 1'b0;
    writenum = '0;
    readnum  = '0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    loadc    = 1'b0;
    loads    = 1'b0;

    case (state_q)
      WAIT: begin
        w = 1'b1;
        if (s) state_d = DECODE;
      end
      DECODE: begin
        if ((opcode == OPC_MOV) && (op == OP_MOV_IMM))      state_d = WRITE_IMM;
        else if ((opcode == OPC_MOV) && (op == OP_MOV_REG)) state_d = GET_B;
        else if ((opcode == OPC_ALU) && (op == OP_MVN))     state_d = GET_B;
        else if (opcode == OPC_ALU)                         state_d = GET_A;
        else                                                state_d = WAIT;
      end
      WRITE_IMM: begin
        vsel     = 1'b1;
        write    = 1'b1;
        writenum = rn;
        state_d  = WAIT;
      end
      GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = GET_B;
      end
      GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = (opcode == OPC_MOV) ? ALU_MOV : ALU;
      end
      ALU: begin
        shift = sh;
        ALUop = op;
        if (op == OP_CMP) begin
          loads   = 1'b1;
          state_d = WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = WRITE_REG;
        end
      end
      ALU_MOV: begin
        shift   = sh;
        asel    = 1'b1;
        ALUop   = OP_ADD;
        loadc   = 1'b1;
        state_d = WRITE_REG;
      end
      WRITE_REG: begin
        write    = 1'b1;
        writenum = rd;
        state_d  = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  assign illegal = illegal_q;

endmodule
`default_nettype wire

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Moore-style instruction sequencer for the 16-bit register/ALU datapath: captures one instruction, decodes it, and steps the datapath control strobes through fetch-operand, ALU and writeback states.
- Sits between the instruction source (switches or a future fetch unit) and the datapath.
- Also supplies the sign-extended immediate that the datapath receives on its 16-bit data input.
- A start/wait handshake serialises instructions: one instruction in flight, no pipelining.

Parameters:
- DW, 16, datapath word width; the immediate output is sign-extended to DW.
- RW, 3, register-index width for readnum and writenum.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instr  in  16  instruction word
- load  in  1  capture instr into the instruction register (IR)
- s  in  1  start execution of the IR contents
- Z_in  in  1  status flag from the datapath (observation only)
- w  out  1  idle/ready; high only in WAIT
- illegal  out  1  sticky: an undefined encoding was executed
- imm_out  out  DW  sign-extended immediate for the datapath data input
- vsel  out  1  1 selects imm_out as the write data; 0 selects the C register
- write  out  1  register-file write enable
- writenum  out  RW  register-file write index
- readnum  out  RW  register-file read index
- loada  out  1  load the A register
- loadb  out  1  load the B register
- asel  out  1  1 forces the ALU A operand to zero
- bsel  out  1  1 selects the 5-bit immediate as the ALU B operand
- shift  out  2  shifter control
- ALUop  out  2  ALU operation select
- loadc  out  1  load the C register
- loads  out  1  load the status register

Behaviour:
- Interface clocking and reset: one clock; reset is synchronous and active-high. All state updates occur on posedge clk.
- Reset effect:
  - state becomes WAIT; IR and illegal are cleared to 0.
  - In WAIT, every strobe is 0: write, loada, loadb, loadc, loads, vsel, asel, bsel.
  - shift, ALUop, readnum and writenum are 0, and w is 1.
- Reset asserted mid-instruction aborts the instruction on that edge; no further strobes are issued.
- IR fields:
  - opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
  - imm8 = IR[7:0]; imm_out = sign-extension of imm8 to DW (combinational from IR, always driven).
- IR capture: the IR loads instr on an edge where load=1 and state is WAIT. load is ignored in every other state.
- If load and s are high on the same WAIT edge, the IR captures the new word and execution starts on that new word.
- s is sampled only in WAIT (WAIT to DECODE when s=1) and is ignored elsewhere.
- Outputs are a pure function of state and IR; every state not listed below holds the WAIT defaults.
- State sequences:
  - DECODE: one cycle, no strobes; branches on {opcode, op}.
  - 110/10 MOV Rn,#imm8: WRITE_IMM (vsel=1, write=1, writenum=Rn), then WAIT.
  - 110/00 MOV Rd,Rm,sh: GET_B, then ALU_MOV (asel=1, ALUop=00, loadc=1), then WRITE_REG, then WAIT.
  - 101/00 ADD, 101/10 AND: GET_A, then GET_B, then ALU (asel=0, ALUop=op, loadc=1), then WRITE_REG, then WAIT.
  - 101/01 CMP: GET_A, then GET_B, then ALU (ALUop=01, loads=1, loadc=0), then WAIT. No register write.
  - 101/11 MVN: GET_B, then ALU (ALUop=11, loadc=1), then WRITE_REG, then WAIT.
  - Any other {opcode, op}: DECODE sets illegal=1, then WAIT. illegal stays set until reset.
- Per-state strobes:
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - ALU states: shift=sh; bsel=0 for every defined opcode.
  - WRITE_REG: vsel=0, write=1, writenum=Rd.
- Latency, counting posedges from the edge that samples s=1 up to w=1 again:
  - MOV imm: 3
  - MOV reg and MVN: 5
  - CMP: 5
  - ADD and AND: 6
  - illegal: 2
- Exactly one write pulse per writing instruction; write is never asserted together with loada, loadb or loadc.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the state enum (WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, ALU_MOV, WRITE_REG);
  - opcode localparams OPC_MOV=3'b110 and OPC_ALU=3'b101;
  - op and ALUop encodings ADD=00, CMP=01, AND=10, MVN=11.
- Sub-module instr_decoder: combinational field extraction plus sign extension from the IR.

Test Plan:
- Reset for 2 cycles, then idle → w=1, all strobes 0, illegal=0; load pulsed with s=0 leaves state in WAIT.
- Load 0xD007, pulse s → write=1 with vsel=1, writenum=0, imm_out=0x0007 on edge 2; w=1 on edge 3.
- Load 0xD1FE, pulse s → imm_out=0xFFFE, writenum=1, single write pulse.
- Load 0xA148 (ADD R2,R1,R0,LSL#1) → strobe order loada(readnum=1), loadb(readnum=0), loadc(ALUop=00, shift=01), write(writenum=2); w=1 after 6 edges.
- Load 0xA800 (CMP) → loads=1 exactly once and write never asserted; then load 0x0000 and pulse s → illegal=1 and w=1 after 2 edges.
- Assert reset during GET_B of an ADD → next edge in WAIT, no write issued; load, s asserted mid-instruction → no effect on IR or the sequence.
